// File: rtl/srv_mem_line_fill.sv
// srv_mem_line_fill
// Line-fill controller between srv_icache and sm_rom. On a miss request it reads
// LINE_WORDS consecutive 32-bit words from a combinational, word-wide ROM, builds
// the line in a fill buffer and publishes it with a one-cycle response pulse.
// Build option SRV_MEM_PREFETCH_EN adds a one-line next-line prefetch buffer.
//
// state | meaning
// IDLE  | waiting for a request (or starting a prefetch after a response)
// FETCH | reading demand line words from the ROM
// RESP  | ext_rsp_o high for one cycle, ext_data_o holds the new line
// PREF  | reading the next line into the prefetch buffer (SRV_MEM_PREFETCH_EN only)
module srv_mem_line_fill #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int ROM_LAT    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        ext_addr_i,
    input  logic                     ext_req_i,
    output logic                     ext_rsp_o,
    output logic [LINE_WORDS*32-1:0] ext_data_o,
    output logic [ADDR_W-1:0]        rom_addr_o,
    input  logic [31:0]              rom_data_i,
    output logic                     busy_o
);

    localparam int LINE_BYTES = LINE_WORDS * 4;
    localparam int CNT_W      = $clog2(LINE_WORDS);
    localparam int WAIT_W     = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;
    localparam int DATA_W     = LINE_WORDS * 32;

    localparam logic [WAIT_W-1:0] WAIT_LD  = WAIT_W'(ROM_LAT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

`ifdef SRV_MEM_PREFETCH_EN
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_BYTES);
    typedef enum logic [1:0] {IDLE, FETCH, RESP, PREF} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_base_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [DATA_W-1:0]   fill_q;
    logic [DATA_W-1:0]   fill_next;
    logic [DATA_W-1:0]   data_q;
    logic [ADDR_W-1:0]   req_base;
    logic [ADDR_W-1:0]   word_addr;

    logic                load_fetch;
    logic                capture;
    logic                wait_dec;
    logic                commit_fill;

`ifdef SRV_MEM_PREFETCH_EN
    logic [ADDR_W-1:0]   pf_base_q;
    logic [DATA_W-1:0]   pf_data_q;
    logic                pf_valid_q;
    logic                pf_pending_q;
    logic [ADDR_W-1:0]   next_base;
    logic                load_pref;
    logic                commit_pf;
    logic                pf_done;
    logic                pf_clear;

    assign next_base = fetch_base_q + LINE_STEP;
`endif

    // Sub-line offset is dropped; the base is always line aligned, so the word
    // offset can be OR-ed in without carry.
    assign req_base  = ext_addr_i & ~OFF_MASK;
    assign word_addr = fetch_base_q | ADDR_W'({cnt_q, 2'b00});

    // Fill buffer with the current ROM word dropped into slot cnt_q.
    always_comb begin
        fill_next = fill_q;
        fill_next[32*int'(cnt_q) +: 32] = rom_data_i;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_d     = state_q;
        load_fetch  = 1'b0;
        capture     = 1'b0;
        wait_dec    = 1'b0;
        commit_fill = 1'b0;
`ifdef SRV_MEM_PREFETCH_EN
        load_pref   = 1'b0;
        commit_pf   = 1'b0;
        pf_done     = 1'b0;
        pf_clear    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ext_req_i) begin
`ifdef SRV_MEM_PREFETCH_EN
                    if (pf_valid_q && (req_base == pf_base_q)) begin
                        commit_pf = 1'b1;
                        state_d   = RESP;
                    end else begin
                        load_fetch = 1'b1;
                        state_d    = FETCH;
                    end
`else
                    load_fetch = 1'b1;
                    state_d    = FETCH;
`endif
                end
`ifdef SRV_MEM_PREFETCH_EN
                else if (pf_pending_q) begin
                    load_pref = 1'b1;
                    state_d   = PREF;
                end
`endif
            end
            FETCH: begin
                if (wait_q == '0) begin
                    capture = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        commit_fill = 1'b1;
                        state_d     = RESP;
                    end
                end else begin
                    wait_dec = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
`ifdef SRV_MEM_PREFETCH_EN
            PREF: begin
                // A request for a different line wins over the speculative fill.
                if (ext_req_i && (req_base != fetch_base_q)) begin
                    load_fetch = 1'b1;
                    pf_clear   = 1'b1;
                    state_d    = FETCH;
                end else if (wait_q == '0) begin
                    capture = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        if (ext_req_i) begin
                            commit_fill = 1'b1;
                            state_d     = RESP;
                        end else begin
                            pf_done = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    wait_dec = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fill datapath: line base, word counter, ROM wait timer and line registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_base_q <= '0;
            cnt_q        <= '0;
            wait_q       <= '0;
            fill_q       <= '0;
            data_q       <= '0;
        end else begin
            if (load_fetch) begin
                fetch_base_q <= req_base;
                cnt_q        <= '0;
                wait_q       <= WAIT_LD;
            end
`ifdef SRV_MEM_PREFETCH_EN
            else if (load_pref) begin
                fetch_base_q <= next_base;
                cnt_q        <= '0;
                wait_q       <= WAIT_LD;
            end else if (commit_pf) begin
                // Track the served line so the following prefetch targets its successor.
                fetch_base_q <= req_base;
            end
`endif
            else if (capture) begin
                cnt_q  <= cnt_q + 1'b1;
                wait_q <= WAIT_LD;
                fill_q <= fill_next;
            end else if (wait_dec) begin
                wait_q <= wait_q - 1'b1;
            end

            if (commit_fill) begin
                data_q <= fill_next;
            end
`ifdef SRV_MEM_PREFETCH_EN
            else if (commit_pf) begin
                data_q <= pf_data_q;
            end
`endif
        end
    end

`ifdef SRV_MEM_PREFETCH_EN
    // Prefetch buffer bookkeeping; the buffer never drives ext_data_o directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pf_base_q    <= '0;
            pf_data_q    <= '0;
            pf_valid_q   <= 1'b0;
            pf_pending_q <= 1'b0;
        end else begin
            if (load_pref) begin
                pf_base_q  <= next_base;
                pf_valid_q <= 1'b0;
            end else if (pf_clear || commit_pf) begin
                pf_valid_q <= 1'b0;
            end else if (pf_done) begin
                pf_data_q  <= fill_next;
                pf_valid_q <= 1'b1;
            end

            if (state_q == RESP) begin
                pf_pending_q <= 1'b1;
            end else if (load_fetch || load_pref) begin
                pf_pending_q <= 1'b0;
            end
        end
    end
`endif

    assign ext_rsp_o  = (state_q == RESP);
    assign busy_o     = (state_q != IDLE);
    assign ext_data_o = data_q;
`ifdef SRV_MEM_PREFETCH_EN
    assign rom_addr_o = ((state_q == FETCH) || (state_q == PREF)) ? word_addr : '0;
`else
    assign rom_addr_o = (state_q == FETCH) ? word_addr : '0;
`endif

endmodule

// File: tb/tb_srv_mem_line_fill.sv
// Bench for srv_mem_line_fill: three instances (default, 8-word/ROM_LAT=2, 8-bit address)
// against a line-level reference: expected line = ROM words at base..base+4*(LW-1),
// response latency = 1 + LW*(ROM_LAT+1), one ROM word address per (ROM_LAT+1) cycles.
module tb_srv_mem_line_fill;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    int          sel;
    logic        rom_mode;
    logic [31:0] salt;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] last_base [3];

    logic         req0, req1, req2;
    logic         rsp0, rsp1, rsp2;
    logic         busy0, busy1, busy2;
    logic [31:0]  rom_addr0, rom_addr1, rom_data0, rom_data1, rom_data2;
    logic [7:0]   addr2, rom_addr2;
    logic [127:0] data0, data2;
    logic [255:0] data1;

    logic         v_rsp, v_busy;
    logic [31:0]  v_rom_addr;
    logic [255:0] v_data;

    function automatic logic [31:0] rom_fn(input logic [31:0] a, input logic mode,
                                           input logic [31:0] s);
        logic [31:0] idx;
        idx = {2'b00, a[31:2]};
        if (mode == 1'b0) return idx;
        return (idx * 32'h9E37_79B1) ^ s;
    endfunction

    assign req0  = req && (sel == 0);
    assign req1  = req && (sel == 1);
    assign req2  = req && (sel == 2);
    assign addr2 = addr[7:0];
    assign rom_data0 = rom_fn(rom_addr0, rom_mode, salt);
    assign rom_data1 = rom_fn(rom_addr1, rom_mode, salt);
    assign rom_data2 = rom_fn({24'h0, rom_addr2}, rom_mode, salt);

    srv_mem_line_fill u0 (
        .clk(clk), .rst_n(rst_n), .ext_addr_i(addr), .ext_req_i(req0),
        .ext_rsp_o(rsp0), .ext_data_o(data0), .rom_addr_o(rom_addr0),
        .rom_data_i(rom_data0), .busy_o(busy0)
    );

    srv_mem_line_fill #(.LINE_WORDS(8), .ADDR_W(32), .ROM_LAT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .ext_addr_i(addr), .ext_req_i(req1),
        .ext_rsp_o(rsp1), .ext_data_o(data1), .rom_addr_o(rom_addr1),
        .rom_data_i(rom_data1), .busy_o(busy1)
    );

    srv_mem_line_fill #(.LINE_WORDS(4), .ADDR_W(8), .ROM_LAT(0)) u2 (
        .clk(clk), .rst_n(rst_n), .ext_addr_i(addr2), .ext_req_i(req2),
        .ext_rsp_o(rsp2), .ext_data_o(data2), .rom_addr_o(rom_addr2),
        .rom_data_i(rom_data2), .busy_o(busy2)
    );

    // View of the currently selected instance.
    always_comb begin
        v_rsp      = rsp0;
        v_busy     = busy0;
        v_rom_addr = rom_addr0;
        v_data     = {128'h0, data0};
        if (sel == 1) begin
            v_rsp      = rsp1;
            v_busy     = busy1;
            v_rom_addr = rom_addr1;
            v_data     = data1;
        end else if (sel == 2) begin
            v_rsp      = rsp2;
            v_busy     = busy2;
            v_rom_addr = {24'h0, rom_addr2};
            v_data     = {128'h0, data2};
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] line4(input logic [31:0] base);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = rom_fn(base + 32'(4*k), rom_mode, salt);
        return l;
    endfunction

    task automatic reset_check(input string tag);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check({tag, "_rsp"},      256'(v_rsp), 256'(1'b0));
            check({tag, "_data"},     v_data, 256'h0);
            check({tag, "_rom_addr"}, 256'(v_rom_addr), 256'h0);
            check({tag, "_busy"},     256'(v_busy), 256'(1'b0));
        end
    endtask

    // One demand fill on instance s, checked word address by word address.
    task automatic fill(input int s, input logic [31:0] a, input bit drop);
        int lw, lat, total, c;
        logic [31:0] amask, base, exp_a;
        logic [255:0] exp_line;
        bit seen;
        lw    = (s == 1) ? 8 : 4;
        lat   = (s == 1) ? 2 : 0;
        amask = (s == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        base  = a & amask & ~(32'(lw*4) - 32'd1);
        total = 1 + lw*(lat+1);
        exp_line = '0;
        for (int k = 0; k < lw; k++)
            exp_line[32*k +: 32] = rom_fn((base + 32'(4*k)) & amask, rom_mode, salt);
        @(negedge clk);
        sel  = s;
        addr = a;
        req  = 1'b1;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < total + 8) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            if (drop && c == 1) req = 1'b0;
            if (v_rsp) seen = 1'b1;
            else if (c < total) begin
                exp_a = (base + 32'(4*((c-1)/(lat+1)))) & amask;
                check("fill_rom_addr", 256'(v_rom_addr), 256'(exp_a));
                check("fill_busy", 256'(v_busy), 256'(1'b1));
            end
        end
        req = 1'b0;
        check("rsp_latency", 256'(c), 256'(total));
        check("line_data", v_data, exp_line);
        last_base[s] = base;
        @(posedge clk);
        @(negedge clk);
        check("rsp_width", 256'(v_rsp), 256'(1'b0));
        check("data_hold", v_data, exp_line);
        check("idle_busy", 256'(v_busy), 256'(1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst_n    = 1'b0;
        req      = 1'b0;
        addr     = '0;
        sel      = 0;
        rom_mode = 1'b0;
        salt     = 32'h0;
        for (int i = 0; i < 3; i++) last_base[i] = 32'h1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_check("por");
        rst_n = 1'b1;

        // Identity ROM, request 0x14 -> words 4..7.
        rom_mode = 1'b0;
        fill(0, 32'h0000_0014, 1'b0);
        check("t2_line", v_data, {128'h0, 32'h7, 32'h6, 32'h5, 32'h4});

        // Eight words, two wait cycles each: response 25 cycles after the request.
        rom_mode = 1'b1;
        salt     = 32'h5A5A_1234;
        fill(1, 32'h0000_0000, 1'b0);

        // 8-bit address space, top line.
        fill(2, 32'h0000_00F4, 1'b0);
`ifdef SRV_MEM_PREFETCH_EN
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("wrap_pf_addr", 256'(v_rom_addr), 256'(32'(4*k)));
            check("wrap_pf_busy", 256'(v_busy), 256'(1'b1));
            @(posedge clk);
            @(negedge clk);
        end
`endif

        // Reset in the middle of a fill.
        @(negedge clk);
        sel  = 0;
        addr = 32'h0000_0104;
        req  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_check("midrst");
        rst_n = 1'b1;
        fill(0, 32'h0000_0104, 1'b0);

        // Random fills; request sometimes dropped once the fill has started.
        salt = $urandom;
        for (int i = 0; i < 24; i++) begin
            int s, lb;
            logic [31:0] a, am, nb;
            s  = $urandom_range(0, 2);
            a  = $urandom;
            lb = (s == 1) ? 32 : 16;
            am = (s == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
            nb = (last_base[s] + 32'(lb)) & am;
            if (((a & am) & ~32'(lb - 1)) == nb) a = a + 32'(2*lb);
            fill(s, a, $urandom_range(0, 1) == 1);
        end

`ifdef SRV_MEM_PREFETCH_EN
        // Hit in IDLE after a completed prefetch.
        fill(0, 32'h0000_0020, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("pf_busy", 256'(v_busy), 256'(1'b1));
        check("pf_addr", 256'(v_rom_addr), 256'(32'h30));
        repeat (6) @(posedge clk);
        @(negedge clk);
        addr = 32'h0000_0034;
        req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("pf_hit_rsp", 256'(v_rsp), 256'(1'b1));
        check("pf_hit_data", v_data, line4(32'h30));
        req = 1'b0;
        fill(0, 32'h0000_0080, 1'b0);

        // Request joining a running prefetch of the same line.
        fill(0, 32'h0000_0020, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("pf_join_addr", 256'(v_rom_addr), 256'(32'h30));
        addr = 32'h0000_0030;
        req  = 1'b1;
        c    = 0;
        while (!v_rsp && c < 12) begin
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        check("pf_join_lat", 256'(c), 256'(4));
        check("pf_join_data", v_data, line4(32'h30));
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("pf_next_addr", 256'(v_rom_addr), 256'(32'h40));
        check("pf_next_busy", 256'(v_busy), 256'(1'b1));
        // Different line during prefetch aborts it.
        fill(0, 32'h0000_0090, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
